// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-low (0 = segment lit).
package seg_scan_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Phase inside one digit slot: anodes dark (anti-ghosting) or digit lit.
   typedef enum logic {
      SLOT_BLANK = 1'b0,
      SLOT_LIT   = 1'b1
   } slot_phase_e;

   // BCD to active-low segments; non-BCD codes show a dash so a bad
   // counter value is visible rather than silently misread.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
      logic [6:0] seg;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bundle between the decade counters / display pins and the scan driver.
// master: the side that owns count_in and watches the display pins.
// slave:  the scan driver itself.
interface seg_scan_driver_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] count_in;
   logic [6:0]          seg_n;
   logic [DIGITS-1:0]   an_n;
   logic                frame_tick;

   modport master (output count_in, input seg_n, an_n, frame_tick);
   modport slave  (input count_in, output seg_n, an_n, frame_tick);
endinterface

// File: rtl/bcd_seg_decoder.sv
// Combinational BCD to active-low seven-segment decoder.
module bcd_seg_decoder
   import seg_scan_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg_n
);

   assign o_seg_n = bcd_to_seg(i_bcd);

endmodule

// File: rtl/seg_scan_driver.sv
// Seven-segment scan driver for a common-anode display.
// Synchronises rippling BCD counter outputs, snapshots a stable value once
// per frame and time-multiplexes the digits with a short dark gap at the
// start of each slot. Optional leading-zero blanking is compiled in when the
// macro SEG_LEAD_ZERO_BLANK_EN is defined.
module seg_scan_driver
   import seg_scan_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_CYC   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   seg_scan_driver_if.slave  bus
);

   localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
   localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYC);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

   logic [4*DIGITS-1:0] r_sync1;
   logic [4*DIGITS-1:0] r_sync2;
   logic [4*DIGITS-1:0] r_prev;
   logic [4*DIGITS-1:0] r_snap;
   logic [PRE_W-1:0]    r_pre;
   logic [IDX_W-1:0]    r_idx;
   logic [6:0]          r_seg_n;
   logic [DIGITS-1:0]   r_an_n;
   logic                r_frame_tick;

   logic                w_stable;
   logic                w_pre_last;
   logic                w_idx_last;
   logic                w_wrap;
   slot_phase_e         w_phase;
   logic [3:0]          w_digit;
   logic [6:0]          w_dec_seg;
   logic [6:0]          w_seg_next;
   logic [DIGITS-1:0]   w_an_next;

   // A value is only trusted once two consecutive synchronised samples agree,
   // which filters out counter states caught mid-ripple.
   assign w_stable   = (r_sync2 == r_prev);
   assign w_pre_last = (r_pre == PRE_LAST);
   assign w_idx_last = (r_idx == IDX_LAST);
   assign w_wrap     = w_pre_last && w_idx_last;
   assign w_phase    = (r_pre < PRE_BLANK) ? SLOT_BLANK : SLOT_LIT;

   // Two-flop synchroniser plus one history stage for the stability check.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
      end else begin
         r_sync1 <= bus.count_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // Slot prescaler, digit index and once-per-frame snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre  <= '0;
         r_idx  <= '0;
         r_snap <= '0;
      end else begin
         r_pre <= w_pre_last ? '0 : r_pre + PRE_W'(1);
         if (w_pre_last) begin
            r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
         end
         if (w_wrap && w_stable) begin
            r_snap <= r_sync2;
         end
      end
   end

   // Select the current digit out of the snapshot.
   always_comb begin
      w_digit = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_digit = r_snap[4*i +: 4];
         end
      end
   end

   bcd_seg_decoder u_dec (
      .i_bcd   (w_digit),
      .o_seg_n (w_dec_seg)
   );

`ifdef SEG_LEAD_ZERO_BLANK_EN
   logic w_upper_zero;
   logic w_blank;

   // True when this digit and every more significant digit are zero.
   always_comb begin
      w_upper_zero = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if ((IDX_W'(i) >= r_idx) && (r_snap[4*i +: 4] != 4'd0)) begin
            w_upper_zero = 1'b0;
         end
      end
   end

   // Digit 0 always shows, so a zero value still reads "0".
   assign w_blank    = (r_idx != '0) && w_upper_zero;
   assign w_seg_next = w_blank ? SEG_BLANK : w_dec_seg;
`else
   assign w_seg_next = w_dec_seg;
`endif

   // One-low anode pattern for the active digit, all dark during the gap.
   always_comb begin
      w_an_next = '1;
      if (w_phase == SLOT_LIT) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
               w_an_next[i] = 1'b0;
            end
         end
      end
   end

   // Registered pin drivers; reset leaves the display fully dark.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg_n      <= SEG_BLANK;
         r_an_n       <= '1;
         r_frame_tick <= 1'b0;
      end else begin
         r_seg_n      <= w_seg_next;
         r_an_n       <= w_an_next;
         r_frame_tick <= w_wrap;
      end
   end

   assign bus.seg_n      = r_seg_n;
   assign bus.an_n       = r_an_n;
   assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver (DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1).
// Build with SEG_LEAD_ZERO_BLANK_EN defined to exercise leading-zero blanking.
module tb_seg_scan_driver;

   localparam int DIGITS      = 4;
   localparam int REFRESH_DIV = 4;
   localparam int BLANK_CYC   = 1;
   localparam int FRAME       = 16;
   localparam int W           = 16;

   localparam logic [6:0] P0   = 7'b1000000;
   localparam logic [6:0] P1   = 7'b1111001;
   localparam logic [6:0] P2   = 7'b0100100;
   localparam logic [6:0] P3   = 7'b0110000;
   localparam logic [6:0] P4   = 7'b0011001;
   localparam logic [6:0] P5   = 7'b0010010;
   localparam logic [6:0] P7   = 7'b1111000;
   localparam logic [6:0] P9   = 7'b0010000;
   localparam logic [6:0] DASH = 7'b0111111;
   localparam logic [6:0] SB   = 7'b1111111;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

   seg_scan_driver #(
      .DIGITS      (DIGITS),
      .REFRESH_DIV (REFRESH_DIV),
      .BLANK_CYC   (BLANK_CYC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- scoreboard ----------------
   // Entry: {an_n[3:0], seg_n[6:0], lit_len[3:0], steady}
   logic [W-1:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [W-1:0] pack_exp(input logic [3:0] an, input logic [6:0] seg);
      return {an, seg, 4'd3, 1'b1};
   endfunction

   // Expected digit presentations for one frame, digit 0 first.
   task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
      exp_q.push_back(pack_exp(4'hE, s0));
      exp_q.push_back(pack_exp(4'hD, s1));
      exp_q.push_back(pack_exp(4'hB, s2));
      exp_q.push_back(pack_exp(4'h7, s3));
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_tick(input string name, output int cycles);
      bit seen;
      seen   = 1'b0;
      cycles = 0;
      for (int k = 0; k < 2*FRAME + 4; k++) begin
         @(negedge clk);
         cycles++;
         if (bus.frame_tick) begin
            seen = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s actual=no frame_tick in %0d cycles required=frame_tick", name, cycles);
      end
   endtask

   task automatic drain(input string name);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 3*FRAME; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s actual=%0d presentations outstanding required=0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Apply a static value, let it be snapshotted, then expect one frame.
   task automatic show_value(input string name, input logic [15:0] v,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
      int c;
      #1 bus.count_in = v;
      wait_tick({name, "_tick1"}, c);
      wait_tick({name, "_tick2"}, c);
      push_frame(s0, s1, s2, s3);
      drain(name);
   endtask

   // ---------------- monitor ----------------
   logic [3:0] m_an;
   logic [6:0] m_seg;
   logic [3:0] m_len;
   logic       m_steady;
   logic       m_in_pres;
   logic       m_prev_lit;
   int         m_gap;

   initial begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      m_in_pres  = 1'b0;
      m_prev_lit = 1'b0;
      m_gap      = 0;
      m_an       = 4'hF;
      m_seg      = SB;
      m_len      = 4'd0;
      m_steady   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_in_pres  = 1'b0;
            m_prev_lit = 1'b0;
            m_gap      = 0;
         end else begin
            m_gap++;
            if (bus.frame_tick) begin
               n_tests++;
               if (m_gap != FRAME) begin
                  n_fail++;
                  $display("FAIL frame_tick_gap actual=%0d required=%0d", m_gap, FRAME);
               end
               m_gap = 0;
            end else if (m_gap > FRAME) begin
               n_tests++;
               n_fail++;
               $display("FAIL frame_tick_gap actual=none after %0d required=%0d", m_gap, FRAME);
               m_gap = 0;
            end
            if (bus.an_n != 4'hF) begin
               if (!m_prev_lit) begin
                  if (exp_q.size() > 0) begin
                     m_in_pres = 1'b1;
                     m_an      = bus.an_n;
                     m_seg     = bus.seg_n;
                     m_len     = 4'd1;
                     m_steady  = 1'b1;
                  end
               end else if (m_in_pres) begin
                  if (m_len != 4'hF) m_len++;
                  if (bus.an_n != m_an || bus.seg_n != m_seg) m_steady = 1'b0;
               end
               m_prev_lit = 1'b1;
            end else begin
               if (m_prev_lit && m_in_pres) begin
                  a = {m_an, m_seg, m_len, m_steady};
                  n_tests++;
                  if (exp_q.size() == 0) begin
                     n_fail++;
                     $display("FAIL digit_present actual=an %h seg %b len %0d required=none queued",
                              m_an, m_seg, m_len);
                  end else begin
                     e = exp_q.pop_front();
                     if (a !== e) begin
                        n_fail++;
                        $display("FAIL digit_present actual=an %h seg %b len %0d steady %b required=an %h seg %b len %0d steady %b",
                                 a[15:12], a[11:5], a[4:1], a[0], e[15:12], e[11:5], e[4:1], e[0]);
                     end
                  end
                  m_in_pres = 1'b0;
               end
               m_prev_lit = 1'b0;
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      int  c;
      bit  saw;
      bit  found;
      bus.count_in = 16'h0000;
      rst_n        = 1'b0;

      // Reset values
      repeat (5) @(negedge clk);
      check("rst_seg_n", 32'(bus.seg_n), 32'(SB));
      check("rst_an_n", 32'(bus.an_n), 32'hF);
      check("rst_frame_tick", 32'(bus.frame_tick), 32'h0);
      #1 rst_n = 1'b1;

      // Static value over two frames
      bus.count_in = 16'h1234;
      wait_tick("static_tick1", c);
      wait_tick("static_tick2", c);
      push_frame(P4, P3, P2, P1);
      push_frame(P4, P3, P2, P1);
      drain("static_1234");

      // Ripple rejection across a wrap: snapshot must keep 1234
      wait_tick("ripple_tick0", c);
      repeat (8) @(negedge clk);
      saw = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (bus.frame_tick) begin
            push_frame(P4, P3, P2, P1);
            saw = 1'b1;
         end
         #1 bus.count_in = i[0] ? 16'h6666 : 16'h5555;
      end
      check("ripple_wrap_seen", 32'(saw), 32'h1);

      // Then hold 0009: must appear within one frame plus 4 cycles
      bus.count_in = 16'h0009;
      wait_tick("hold_tick", c);
      check("hold_latency_ok", 32'((c + 2) <= (FRAME + 4)), 32'h1);
`ifdef SEG_LEAD_ZERO_BLANK_EN
      push_frame(P9, SB, SB, SB);
`else
      push_frame(P9, P0, P0, P0);
`endif
      drain("hold_0009");

      // Invalid codes show a dash
      show_value("invalid_a0f5", 16'hA0F5, P5, DASH, P0, DASH);

      // Leading-zero cases
`ifdef SEG_LEAD_ZERO_BLANK_EN
      show_value("lead_0070", 16'h0070, P0, P7, SB, SB);
      show_value("lead_0000", 16'h0000, P0, SB, SB, SB);
`else
      show_value("lead_0070", 16'h0070, P0, P7, P0, P0);
      show_value("lead_0000", 16'h0000, P0, P0, P0, P0);
`endif

      // Asynchronous reset mid-slot while a digit is lit
      found = 1'b0;
      for (int k = 0; k < 2*FRAME; k++) begin
         @(posedge clk);
         #1;
         if (bus.an_n != 4'hF && bus.seg_n != SB) begin
            found = 1'b1;
            break;
         end
      end
      check("midrst_lit_before", 32'(found), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_seg_n", 32'(bus.seg_n), 32'(SB));
      check("midrst_an_n", 32'(bus.an_n), 32'hF);
      check("midrst_frame_tick", 32'(bus.frame_tick), 32'h0);
      @(negedge clk);
      #1 rst_n = 1'b1;

      // Restart at digit 0: snapshot is 0 after reset, count_in is 0000
`ifdef SEG_LEAD_ZERO_BLANK_EN
      push_frame(P0, SB, SB, SB);
      push_frame(P0, SB, SB, SB);
`else
      push_frame(P0, P0, P0, P0);
      push_frame(P0, P0, P0, P0);
`endif
      drain("restart_after_reset");

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
